// File: rtl/goldschmidt_ctrl.sv
// Goldschmidt divider control FSM.
// Sequences the multiplexer selects and register load enables of a Goldschmidt
// divider datapath: load N, load D, then iters pairs of (N update, D update)
// refinement steps, and finally a one-cycle done pulse. All outputs are Moore
// decodes of the state register and the iteration index register.
module goldschmidt_ctrl #(
   parameter int ITER_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ITER_W-1:0] iters,
   output logic [1:0]        sel_ND_mux,
   output logic              sel_K_mux,
   output logic              load_regN,
   output logic              load_regD,
   output logic              busy,
   output logic              done,
   output logic [ITER_W-1:0] iter_idx
);

   // Multiplicand select encodings for sel_ND_mux.
   localparam logic [1:0] SEL_N_IN  = 2'b00;
   localparam logic [1:0] SEL_D_IN  = 2'b01;
   localparam logic [1:0] SEL_REG_N = 2'b10;
   localparam logic [1:0] SEL_REG_D = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_N = 3'd1,
      S_LOAD_D = 3'd2,
      S_ITER_N = 3'd3,
      S_ITER_D = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ITER_W-1:0] count_q, count_d;
   logic [ITER_W-1:0] idx_q,   idx_d;

   // One bit wider than the index so the maximum count never wraps the compare.
   logic [ITER_W:0]   idx_inc;

   // Incremented iteration index, extended so iters = 2^ITER_W-1 terminates cleanly.
   always_comb begin
      idx_inc = {1'b0, idx_q} + {{ITER_W{1'b0}}, 1'b1};
   end

   // Next-state logic: sequencing, count capture, iteration index update, abort.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d = S_LOAD_N;
               count_d = iters;
               idx_d   = '0;
            end
         end
         S_LOAD_N: begin
            state_d = S_LOAD_D;
         end
         S_LOAD_D: begin
            idx_d = '0;
            if (count_q != '0) begin
               state_d = S_ITER_N;
            end else begin
               state_d = S_DONE;
            end
         end
         S_ITER_N: begin
            // regN always takes its K product before regD is overwritten.
            state_d = S_ITER_D;
         end
         S_ITER_D: begin
            if (idx_inc < {1'b0, count_q}) begin
               idx_d   = idx_inc[ITER_W-1:0];
               state_d = S_ITER_N;
            end else begin
               idx_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Back-to-back operation: a waiting start skips IDLE entirely.
            if (start) begin
               state_d = S_LOAD_N;
               count_d = iters;
               idx_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase

      // Abort wins over everything except reset; it cancels without a done pulse.
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         idx_d   = '0;
      end
   end

   // State, captured count and iteration index registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
      end
   end

   // Moore output decode; load_regN and load_regD are mutually exclusive by construction.
   always_comb begin
      sel_ND_mux = SEL_N_IN;
      sel_K_mux  = 1'b1;
      load_regN  = 1'b0;
      load_regD  = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      iter_idx   = '0;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
         end
         S_LOAD_N: begin
            load_regN = 1'b1;
         end
         S_LOAD_D: begin
            sel_ND_mux = SEL_D_IN;
            load_regD  = 1'b1;
         end
         S_ITER_N: begin
            sel_ND_mux = SEL_REG_N;
            sel_K_mux  = 1'b0;
            load_regN  = 1'b1;
            iter_idx   = idx_q;
         end
         S_ITER_D: begin
            sel_ND_mux = SEL_REG_D;
            sel_K_mux  = 1'b0;
            load_regD  = 1'b1;
            iter_idx   = idx_q;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Scoreboard bench for goldschmidt_ctrl: stimulus pushes the expected per-cycle
// output vector of every operation into a queue; a negedge monitor pops and
// compares whenever the cycle of the queue head is reached.
module tb_goldschmidt_ctrl;

   localparam int ITER_W = 3;

   // State codes used only to build expected output vectors.
   localparam int E_IDLE = 0;
   localparam int E_LN   = 1;
   localparam int E_LD   = 2;
   localparam int E_IN   = 3;
   localparam int E_ID   = 4;
   localparam int E_DONE = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              abort;
   logic [ITER_W-1:0] iters;
   logic [1:0]        sel_ND_mux;
   logic              sel_K_mux;
   logic              load_regN;
   logic              load_regD;
   logic              busy;
   logic              done;
   logic [ITER_W-1:0] iter_idx;

   typedef struct {
      int                cyc;
      int                test;
      logic [1:0]        nd;
      logic              k;
      logic              ln;
      logic              ld;
      logic              bz;
      logic              dn;
      logic [ITER_W-1:0] idx;
   } exp_t;

   exp_t q[$];
   int   cyc      = 0;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   test_id  = 0;

   goldschmidt_ctrl #(.ITER_W(ITER_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .iters      (iters),
      .sel_ND_mux (sel_ND_mux),
      .sel_K_mux  (sel_K_mux),
      .load_regN  (load_regN),
      .load_regD  (load_regD),
      .busy       (busy),
      .done       (done),
      .iter_idx   (iter_idx)
   );

   always #5 clk = ~clk;

   // Cycle k is the interval after the k-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Push the expected outputs of one state at absolute cycle c.
   task automatic push_state(input int c, input int st, input int idx);
      exp_t e;
      e.cyc = c; e.test = test_id; e.idx = ITER_W'(idx);
      e.nd = 2'b00; e.k = 1'b1; e.ln = 1'b0; e.ld = 1'b0; e.bz = 1'b1; e.dn = 1'b0;
      case (st)
         E_IDLE: begin e.bz = 1'b0; e.idx = '0; end
         E_LN:   begin e.ln = 1'b1; e.idx = '0; end
         E_LD:   begin e.nd = 2'b01; e.ld = 1'b1; e.idx = '0; end
         E_IN:   begin e.nd = 2'b10; e.k = 1'b0; e.ln = 1'b1; end
         E_ID:   begin e.nd = 2'b11; e.k = 1'b0; e.ld = 1'b1; end
         default: begin e.dn = 1'b1; e.idx = '0; end
      endcase
      q.push_back(e);
   endtask

   // Expected trace of an operation whose start is accepted at the edge ending
   // cycle c0; only the first 'upto' cycles are pushed (abort/reset cases).
   task automatic push_op(input int c0, input int it, input int upto);
      int k;
      k = 1;
      if (k <= upto) push_state(c0 + k, E_LN, 0);
      k++;
      if (k <= upto) push_state(c0 + k, E_LD, 0);
      k++;
      for (int i = 0; i < it; i++) begin
         if (k <= upto) push_state(c0 + k, E_IN, i);
         k++;
         if (k <= upto) push_state(c0 + k, E_ID, i);
         k++;
      end
      if (k <= upto) push_state(c0 + k, E_DONE, 0);
   endtask

   // Single operation from IDLE; iters is scrambled after acceptance.
   task automatic run_op(input int it);
      int c0;
      c0 = cyc;
      start = 1'b1;
      iters = ITER_W'(it);
      push_op(c0, it, 1000);
      push_state(c0 + 4 + 2 * it, E_IDLE, 0);
      @(negedge clk);
      start = 1'b0;
      iters = ~ITER_W'(it);
      repeat (3 + 2 * it) @(negedge clk);
   endtask

   // Monitor: compare the queue head when its cycle is reached.
   always @(negedge clk) begin
      exp_t       e;
      logic [9:0] act;
      logic [9:0] req;
      bit         done_ok;
      done_ok = 1'b0;
      act = {sel_ND_mux, sel_K_mux, load_regN, load_regD, busy, done, iter_idx};
      while (q.size() > 0 && q[0].cyc < cyc) begin
         e = q.pop_front();
         n_assert++; n_fail++;
         $display("FAIL stale_expectation test %0d cycle %0d never compared (now %0d)", e.test, e.cyc, cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         req = {e.nd, e.k, e.ln, e.ld, e.bz, e.dn, e.idx};
         n_assert++;
         if (act !== req) begin
            n_fail++;
            $display("FAIL outputs test %0d cycle %0d: got nd=%b k=%b ln=%b ld=%b busy=%b done=%b idx=%0d, need nd=%b k=%b ln=%b ld=%b busy=%b done=%b idx=%0d",
                     e.test, cyc, act[9:8], act[7], act[6], act[5], act[4], act[3], act[2:0],
                     req[9:8], req[7], req[6], req[5], req[4], req[3], req[2:0]);
         end
         done_ok = e.dn;
      end
      if (done === 1'b1 && !done_ok) begin
         n_assert++; n_fail++;
         $display("FAIL unexpected_done cycle %0d: got done=1, need 0", cyc);
      end
      n_assert++;
      if ((load_regN & load_regD) !== 1'b0) begin
         n_fail++;
         $display("FAIL load_exclusive cycle %0d: got ln&ld=%b, need 0", cyc, load_regN & load_regD);
      end
   end

   // Absolute time bound in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      reset = 1'b0; start = 1'b0; abort = 1'b0; iters = '0;

      // Reset state, with start asserted during reset to be discarded.
      test_id = 0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      push_state(cyc + 1, E_IDLE, 0);
      push_state(cyc + 2, E_IDLE, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1; start = 1'b0;
      push_state(cyc + 1, E_IDLE, 0);
      push_state(cyc + 2, E_IDLE, 0);
      repeat (2) @(negedge clk);

      // iters=2: done at cycle 7, busy cycles 1-7.
      test_id = 1; run_op(2);
      // iters=0: LOAD_N, LOAD_D, DONE.
      test_id = 2; run_op(0);
      // iters=7: done at cycle 17, index 0..6 without wrap.
      test_id = 3; run_op(7);

      // start held with iters=1: DONE goes straight to LOAD_N every 5 cycles.
      test_id = 4;
      c0 = cyc;
      start = 1'b1; iters = 3'd1;
      for (int j = 0; j < 4; j++) push_op(c0 + 5 * j, 1, 1000);
      push_state(c0 + 21, E_IDLE, 0);
      repeat (20) @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);

      // Abort in the second ITER_N of an iters=3 run.
      test_id = 5;
      c0 = cyc;
      start = 1'b1; iters = 3'd3;
      push_op(c0, 3, 5);
      push_state(c0 + 6, E_IDLE, 0);
      push_state(c0 + 7, E_IDLE, 0);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (2) @(negedge clk);

      // abort together with start in IDLE: nothing starts.
      test_id = 6;
      start = 1'b1; abort = 1'b1; iters = 3'd2;
      push_state(cyc + 1, E_IDLE, 0);
      push_state(cyc + 2, E_IDLE, 0);
      @(negedge clk);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      @(negedge clk);

      // abort together with start in DONE: abort wins, no restart.
      test_id = 7;
      c0 = cyc;
      start = 1'b1; iters = 3'd0;
      push_op(c0, 0, 1000);
      push_state(c0 + 4, E_IDLE, 0);
      push_state(c0 + 5, E_IDLE, 0);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      repeat (2) @(negedge clk);

      // Reset in ITER_D with start held, then a normal run.
      test_id = 8;
      c0 = cyc;
      start = 1'b1; iters = 3'd2;
      push_op(c0, 2, 4);
      push_state(c0 + 5, E_IDLE, 0);
      push_state(c0 + 6, E_IDLE, 0);
      push_state(c0 + 7, E_IDLE, 0);
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1; start = 1'b0;
      @(negedge clk);
      test_id = 9; run_op(1);

      // Drain the scoreboard within a bounded number of cycles.
      for (int w = 0; w < 50 && q.size() > 0; w++) @(negedge clk);
      n_assert++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, need 0", q.size());
      end
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
